arm_controller: RTL

Control unit for the single-cycle ARM-subset processor, directly upstream of the datapath. Decodes the instruction fields exported by the datapath (Cond, Op, Funct, Rd) into the datapath control signals. Holds the architectural NZCV condition-flag register and evaluates the 4-bit condition code. Tracks undefined opcodes in a sticky status bit.

---
 rtl/arm_controller.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/arm_controller.sv
`default_nettype none
// ============================================================================
// Module   : arm_controller
// Purpose  : Control unit for a single-cycle ARM-subset core. Decodes
//            Cond/Op/Funct/Rd into datapath controls, holds NZCV flags,
//            evaluates the condition code and tracks undefined opcodes.
// Revision : 1.0 - initial release
// ============================================================================
module arm_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCSrc,
  output logic       Reg_Write,
  output logic       Mem_Write,
  output logic       MemtoReg,
  output logic       ALUSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControl,
  output logic [3:0] Flags,
  output logic       Undef
);

  localparam logic [1:0] C_OP_DP  = 2'b00;
  localparam logic [1:0] C_OP_MEM = 2'b01;
  localparam logic [1:0] C_OP_BR  = 2'b10;
  localparam logic [3:0] C_ALU_ADD = 4'b0100;
  localparam logic [3:0] C_ALU_SUB = 4'b0010;
  localparam logic [3:0] C_RD_PC   = 4'b1111;

  logic       flags_n_q, flags_z_q, flags_c_q, flags_v_q;
  logic [3:0] flags_q, flags_d;
  logic       undef_q, undef_d;

  logic [3:0] w_cmd;
  logic       w_pc_dec, w_rw_dec, w_mw_dec;
  logic       w_fw_nz, w_fw_cv, w_undef_dec;
  logic       w_cond_ex;

  assign w_cmd   = Funct[4:1];
  assign flags_q = {flags_n_q, flags_z_q, flags_c_q, flags_v_q};

  // Instruction decode: unconditional control fields plus ungated write enables
  always_comb begin
    w_pc_dec    = 1'b0;
    w_rw_dec    = 1'b0;
    w_mw_dec    = 1'b0;
    w_fw_nz     = 1'b0;
    w_fw_cv     = 1'b0;
    w_undef_dec = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrc      = 1'b0;
    ImmSrc      = 2'b00;
    RegSrc      = 2'b00;
    ALUControl  = 4'b0000;
    case (Op)
      C_OP_DP: begin
        ALUSrc = Funct[5];
        case (w_cmd)
          4'b1000: ALUControl = 4'b0000;  // TST
          4'b1001: ALUControl = 4'b0001;  // TEQ
          4'b1010: ALUControl = C_ALU_SUB; // CMP
          4'b1011: ALUControl = C_ALU_ADD; // CMN
          default: ALUControl = w_cmd;
        endcase
        // Compare/test ops only update flags, and always do so
        w_rw_dec = (w_cmd[3:2] != 2'b10);
        w_fw_nz  = Funct[0] | (w_cmd[3:2] == 2'b10);
        // Arithmetic ops (SUB..RSC, CMP, CMN) also produce C and V
        w_fw_cv  = w_fw_nz &
                   (((w_cmd[3] == 1'b0) && (w_cmd[2:1] != 2'b00)) ||
                    (w_cmd[3:1] == 3'b101));
        w_pc_dec = w_rw_dec & (Rd == C_RD_PC);
      end
      C_OP_MEM: begin
        ALUSrc     = ~Funct[5];
        ImmSrc     = 2'b01;
        ALUControl = Funct[3] ? C_ALU_ADD : C_ALU_SUB;
        if (Funct[0]) begin
          w_rw_dec = 1'b1;
          MemtoReg = 1'b1;
          w_pc_dec = (Rd == C_RD_PC);
        end else begin
          w_mw_dec = 1'b1;
          RegSrc   = 2'b10;
        end
      end
      C_OP_BR: begin
        w_pc_dec   = 1'b1;
        ALUSrc     = 1'b1;
        ImmSrc     = 2'b10;
        RegSrc     = 2'b01;
        ALUControl = C_ALU_ADD;
      end
      default: w_undef_dec = 1'b1;
    endcase
  end

  // Condition evaluation against the flags left by earlier instructions
  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      4'b0000: w_cond_ex = flags_z_q;
      4'b0001: w_cond_ex = ~flags_z_q;
      4'b0010: w_cond_ex = flags_c_q;
      4'b0011: w_cond_ex = ~flags_c_q;
      4'b0100: w_cond_ex = flags_n_q;
      4'b0101: w_cond_ex = ~flags_n_q;
      4'b0110: w_cond_ex = flags_v_q;
      4'b0111: w_cond_ex = ~flags_v_q;
      4'b1000: w_cond_ex = flags_c_q & ~flags_z_q;
      4'b1001: w_cond_ex = ~flags_c_q | flags_z_q;
      4'b1010: w_cond_ex = (flags_n_q == flags_v_q);
      4'b1011: w_cond_ex = (flags_n_q != flags_v_q);
      4'b1100: w_cond_ex = ~flags_z_q & (flags_n_q == flags_v_q);
      4'b1101: w_cond_ex = flags_z_q | (flags_n_q != flags_v_q);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;  // 1111 never executes
    endcase
  end

  // Next-state for flags and the sticky undefined bit, gated by the condition
  always_comb begin
    flags_d = flags_q;
    if (w_fw_nz && w_cond_ex) flags_d[3:2] = ALUFlags[3:2];
    if (w_fw_cv && w_cond_ex) flags_d[1:0] = ALUFlags[1:0];
    undef_d = undef_q | (w_undef_dec & w_cond_ex);
  end

  // State registers, cleared immediately when reset goes low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_n_q <= 1'b0;
      flags_z_q <= 1'b0;
      flags_c_q <= 1'b0;
      flags_v_q <= 1'b0;
      undef_q   <= 1'b0;
    end else begin
      {flags_n_q, flags_z_q, flags_c_q, flags_v_q} <= flags_d;
      undef_q <= undef_d;
    end
  end

  // Architectural writes require a passing condition and released reset
  assign PCSrc     = w_pc_dec & w_cond_ex & reset;
  assign Reg_Write = w_rw_dec & w_cond_ex & reset;
  assign Mem_Write = w_mw_dec & w_cond_ex & reset;
  assign Flags     = flags_q;
  assign Undef     = undef_q;

endmodule
`default_nettype wire
